seq_core: RTL and testbench
===========================

# seq_core

Parametrised microcode sequencer that fetches 40-bit instructions from the instruction SRAM and drives up to N_UNIT execution sub-modules (wbuf_send / output_send / cal class) through a START/BUSY handshake. It provides N_CNT hardware loop counters, N_AG stride address generators and a latched static-control word. It replaces the fixed four-counter sequencer with an explicit fetch/execute state machine, HALT/DONE and illegal-opcode detection.

## Interface

- PCW, 14, instruction address width (≤32)
- CW, 8, loop counter width (≤32)
- N_CNT, 4, number of loop counters (1..16)
- AW, 16, address generator width (≤32)
- N_AG, 3, number of address generators (1..16)
- N_UNIT, 3, number of execution units (1..32)
- SIGW, 24, static control word width (≤32)
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  pulse; begins execution at pc 0 from IDLE or HALTED
- PURGE  in  1  synchronous abort to IDLE; clears pc, counters, AGs, CTRL
- QI  in  40  instruction word, valid the cycle after RCEBI low
- RADDRI  out  PCW  instruction address
- RCEBI  out  1  instruction SRAM chip enable, active low
- UNIT_START  out  N_UNIT  one-cycle start pulse per unit
- UNIT_BUSY  in  N_UNIT  unit busy flags
- AG_OUT  out  N_AG*AW  address generator values, AG a at [a*AW +: AW]
- CTRL  out  SIGW  static control word
- BUSY  out  1  high in any state except IDLE/HALTED
- DONE  out  1  high while HALTED after HALT
- ERR  out  1  sticky illegal-opcode flag, cleared by START/PURGE/RST

## Operation

- Instruction fields: OP=QI[39:36], SEL=QI[35:32], IMM=QI[31:0].
- States: IDLE, FETCH, EXEC, WAIT, HALTED.
- IDLE/HALTED + START -> FETCH with pc=0, ERR cleared, DONE cleared; counters/AGs/CTRL retained.
- FETCH: RCEBI=0, RADDRI=pc -> EXEC. EXEC decodes QI:
- 0 NOP: pc+1.
- 1 LDCNT: cnt[SEL] <= IMM[CW-1:0]; pc+1.
- 2 LOOP: if cnt[SEL] ≤ 1 then cnt[SEL] <= 0, pc+1; else cnt[SEL]-1, pc <= IMM[PCW-1:0]. Body with LDCNT n runs n times (n=0 behaves as 1).
- 3 JMP: pc <= IMM[PCW-1:0].
- 4 AGSET: ag[SEL] <= IMM[AW-1:0]; pc+1.
- 5 AGADD: ag[SEL] <= ag[SEL] + IMM[AW-1:0] mod 2^AW (two's complement, so negative strides wrap); pc+1.
- 6 RUN: UNIT_START <= IMM[N_UNIT-1:0] for one cycle, then -> WAIT. A zero mask behaves as NOP.
- 7 SETCTRL: CTRL <= IMM[SIGW-1:0]; pc+1.
- 8 HALT: -> HALTED, DONE=1.
- 9..15, or SEL ≥ N_CNT / N_AG on an indexed op: ERR=1, -> HALTED, DONE=0, no state change.
- Non-halting EXEC -> FETCH.
- WAIT: when (UNIT_BUSY & mask) == 0, pc+1 -> FETCH; else stay.
- AG_OUT and CTRL are held stable throughout WAIT.
- pc+1 wraps from 2^PCW-1 to 0.

## Timing

- Reset/PURGE values: state IDLE, pc=0, counters=0, AGs=0, CTRL=0, RADDRI=0, RCEBI=1, UNIT_START=0, BUSY=0, DONE=0, ERR=0.
- PURGE has priority over START; RST has priority over everything.
- Non-RUN instruction: 2 cycles (FETCH, EXEC). RUN: 2 cycles + WAIT.
- UNIT_START is registered: high in the cycle after EXEC of RUN, which is the first WAIT cycle.
- UNIT_BUSY is first sampled the cycle after UNIT_START. A unit must raise BUSY by then or be finished.
- Unmasked UNIT_BUSY bits are ignored.
- START while BUSY=1 is ignored.
- PURGE mid-WAIT aborts immediately. UNIT_START is not re-issued; units are purged separately.
- RCEBI is low only in FETCH.
- All outputs are registered except BUSY/DONE, which decode state.

## Structure

- Package seq_pkg: opcode enum (4 bits, values above), field position constants OP/SEL/IMM, state enum.
- One sub-module, seq_agen, instantiated N_AG times: load/add with AW width and held output.
- Loop counters are an inline array.

## Test plan

- Reset, then program NOP, HALT; START pulse -> RADDRI 0,1; DONE=1 at cycle 5; BUSY low afterwards.
- LDCNT c0=3; AGADD a0,+4; LOOP c0->1; HALT -> AGADD executes 3 times, AG_OUT[a0]=12, cnt0=0.
- AGSET a1=0x0002; AGADD a1,0xFFFF (AW=16) -> AG1=0x0001. Then AGADD 0xFFFE -> 0xFFFF (wrap).
- RUN mask 0b101 with unit0 busy 5 cycles and unit2 busy 9 cycles -> single START pulse on bits 0 and 2; FETCH of next pc follows the cycle after unit2 BUSY falls; unit1 BUSY toggling has no effect.
- Opcode 0xC, or LDCNT SEL=5 with N_CNT=4 -> ERR=1, DONE=0, HALTED; next START clears ERR.
- PURGE asserted during WAIT with START in the same cycle -> IDLE, pc=0, CTRL=0, no UNIT_START; later START runs from 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared opcode/state encodings and instruction field positions for the
// microcode sequencer.
package seq_pkg;

  localparam int INSTR_W = 40;
  localparam int OP_MSB  = 39;
  localparam int OP_LSB  = 36;
  localparam int SEL_MSB = 35;
  localparam int SEL_LSB = 32;
  localparam int IMM_MSB = 31;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_LDCNT   = 4'd1,
    OP_LOOP    = 4'd2,
    OP_JMP     = 4'd3,
    OP_AGSET   = 4'd4,
    OP_AGADD   = 4'd5,
    OP_RUN     = 4'd6,
    OP_SETCTRL = 4'd7,
    OP_HALT    = 4'd8
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= 4'd8);
  endfunction

endpackage

// File: rtl/seq_agen.sv
// Single stride address generator: absolute load or modular add, value held
// otherwise.
module seq_agen
  import seq_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld,
  input  logic          add,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] q
);

  logic [AW-1:0] val_q, val_d;

  // next value: load wins over add, otherwise hold
  always_comb begin
    val_d = val_q;
    if (ld) begin
      val_d = din;
    end else if (add) begin
      val_d = val_q + din;
    end else begin
      val_d = val_q;
    end
  end

  // state register, cleared by reset or purge
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/seq_core.sv
// Microcode sequencer: fetch/execute FSM with loop counters, address
// generators, static control word and a START/BUSY unit handshake.
module seq_core
  import seq_pkg::*;
#(
  parameter int PCW    = 14,
  parameter int CW     = 8,
  parameter int N_CNT  = 4,
  parameter int AW     = 16,
  parameter int N_AG   = 3,
  parameter int N_UNIT = 3,
  parameter int SIGW   = 24
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 PURGE,
  input  logic [INSTR_W-1:0]   QI,
  output logic [PCW-1:0]       RADDRI,
  output logic                 RCEBI,
  output logic [N_UNIT-1:0]    UNIT_START,
  input  logic [N_UNIT-1:0]    UNIT_BUSY,
  output logic [N_AG*AW-1:0]   AG_OUT,
  output logic [SIGW-1:0]      CTRL,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR
);

  state_e             state_q, state_d;
  logic [PCW-1:0]     pc_q, pc_d, pc_inc_s;
  logic [CW-1:0]      cnt_q [N_CNT];
  logic [CW-1:0]      cnt_d [N_CNT];
  logic [CW-1:0]      cnt_sel_s;
  logic [SIGW-1:0]    ctrl_q, ctrl_d;
  logic               err_q, err_d;
  logic [PCW-1:0]     raddr_q, raddr_d;
  logic               rcebi_q, rcebi_d;
  logic [N_UNIT-1:0]  ustart_q, ustart_d, mask_q, mask_d;
  logic [N_AG-1:0]    ag_ld_s, ag_add_s;

  opcode_e            op_s;
  logic [3:0]         sel_s;
  logic [31:0]        imm_s;
  logic               illegal_s, unused_imm_s;

  assign op_s         = opcode_e'(QI[OP_MSB:OP_LSB]);
  assign sel_s        = QI[SEL_MSB:SEL_LSB];
  assign imm_s        = QI[IMM_MSB:IMM_LSB];
  assign unused_imm_s = ^imm_s;
  assign pc_inc_s     = pc_q + PCW'(1);

  // selected counter value and illegal-instruction decode
  always_comb begin
    cnt_sel_s = '0;
    for (int i = 0; i < N_CNT; i++) begin
      cnt_sel_s = (sel_s == 4'(i)) ? cnt_q[i] : cnt_sel_s;
    end
    if (!op_is_legal(QI[OP_MSB:OP_LSB])) begin
      illegal_s = 1'b1;
    end else if (op_s == OP_LDCNT || op_s == OP_LOOP) begin
      illegal_s = (int'({28'd0, sel_s}) >= N_CNT);
    end else if (op_s == OP_AGSET || op_s == OP_AGADD) begin
      illegal_s = (int'({28'd0, sel_s}) >= N_AG);
    end else begin
      illegal_s = 1'b0;
    end
  end

  // fetch/execute next-state logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    err_d    = err_q;
    mask_d   = mask_q;
    ustart_d = '0;
    ag_ld_s  = '0;
    ag_add_s = '0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (START) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          err_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc_s;
        if (illegal_s) begin
          state_d = ST_HALTED;
          pc_d    = pc_q;
          err_d   = 1'b1;
        end else begin
          case (op_s)
            OP_NOP: pc_d = pc_inc_s;
            OP_LDCNT: begin
              for (int i = 0; i < N_CNT; i++) begin
                cnt_d[i] = (sel_s == 4'(i)) ? imm_s[CW-1:0] : cnt_q[i];
              end
            end
            OP_LOOP: begin
              // counter at 0 or 1 falls through so a count of 0 still runs once
              if (cnt_sel_s <= CW'(1)) begin
                for (int i = 0; i < N_CNT; i++) begin
                  cnt_d[i] = (sel_s == 4'(i)) ? '0 : cnt_q[i];
                end
              end else begin
                for (int i = 0; i < N_CNT; i++) begin
                  cnt_d[i] = (sel_s == 4'(i)) ? cnt_sel_s - CW'(1) : cnt_q[i];
                end
                pc_d = imm_s[PCW-1:0];
              end
            end
            OP_JMP: pc_d = imm_s[PCW-1:0];
            OP_AGSET: begin
              for (int a = 0; a < N_AG; a++) begin
                ag_ld_s[a] = (sel_s == 4'(a));
              end
            end
            OP_AGADD: begin
              for (int a = 0; a < N_AG; a++) begin
                ag_add_s[a] = (sel_s == 4'(a));
              end
            end
            OP_RUN: begin
              if (imm_s[N_UNIT-1:0] != '0) begin
                state_d  = ST_WAIT;
                pc_d     = pc_q;
                ustart_d = imm_s[N_UNIT-1:0];
                mask_d   = imm_s[N_UNIT-1:0];
              end else begin
                pc_d = pc_inc_s;
              end
            end
            OP_SETCTRL: ctrl_d = imm_s[SIGW-1:0];
            OP_HALT: begin
              state_d = ST_HALTED;
              pc_d    = pc_q;
            end
            default: begin
              state_d = ST_HALTED;
              pc_d    = pc_q;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_WAIT: begin
        // the start-pulse cycle is skipped: units only report BUSY one cycle later
        if (ustart_q != '0) begin
          state_d = ST_WAIT;
        end else if ((UNIT_BUSY & mask_q) == '0) begin
          state_d = ST_FETCH;
          pc_d    = pc_inc_s;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (PURGE) begin
      state_d  = ST_IDLE;
      pc_d     = '0;
      ctrl_d   = '0;
      err_d    = 1'b0;
      mask_d   = '0;
      ustart_d = '0;
      ag_ld_s  = '0;
      ag_add_s = '0;
      for (int i = 0; i < N_CNT; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      state_d = state_d;
    end
    rcebi_d = (state_d != ST_FETCH);
    if (PURGE) begin
      raddr_d = '0;
    end else if (state_d == ST_FETCH) begin
      raddr_d = pc_d;
    end else begin
      raddr_d = raddr_q;
    end
  end

  // sequencer state and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ctrl_q   <= '0;
      err_q    <= 1'b0;
      raddr_q  <= '0;
      rcebi_q  <= 1'b1;
      ustart_q <= '0;
      mask_q   <= '0;
      for (int i = 0; i < N_CNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ctrl_q   <= ctrl_d;
      err_q    <= err_d;
      raddr_q  <= raddr_d;
      rcebi_q  <= rcebi_d;
      ustart_q <= ustart_d;
      mask_q   <= mask_d;
      for (int i = 0; i < N_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar a = 0; a < N_AG; a++) begin : g_agen
    seq_agen #(.AW(AW)) u_agen (
      .clk (CLK),
      .rst (RST),
      .clr (PURGE),
      .ld  (ag_ld_s[a]),
      .add (ag_add_s[a]),
      .din (imm_s[AW-1:0]),
      .q   (AG_OUT[a*AW +: AW])
    );
  end

  assign RADDRI     = raddr_q;
  assign RCEBI      = rcebi_q;
  assign UNIT_START = ustart_q;
  assign CTRL       = ctrl_q;
  assign ERR        = err_q;
  assign BUSY       = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign DONE       = (state_q == ST_HALTED) && !err_q;

endmodule

// File: tb/tb_seq_core.sv
// Directed self-checking bench for seq_core with a registered instruction SRAM
// model and simple countdown execution-unit models.
module tb_seq_core;

  localparam int PCW = 14, CW = 8, N_CNT = 4, AW = 16, N_AG = 3, N_UNIT = 3, SIGW = 24;

  logic                CLK = 1'b0;
  logic                RST, START, PURGE;
  logic [39:0]         QI;
  logic [PCW-1:0]      RADDRI;
  logic                RCEBI;
  logic [N_UNIT-1:0]   UNIT_START, UNIT_BUSY;
  logic [N_AG*AW-1:0]  AG_OUT;
  logic [SIGW-1:0]     CTRL;
  logic                BUSY, DONE, ERR;

  int errors = 0;
  int checks = 0;

  logic [39:0] mem [0:15];
  int          ucnt [N_UNIT];
  int          udur [N_UNIT];
  logic        tog1;

  seq_core #(.PCW(PCW), .CW(CW), .N_CNT(N_CNT), .AW(AW), .N_AG(N_AG),
             .N_UNIT(N_UNIT), .SIGW(SIGW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .PURGE(PURGE), .QI(QI),
    .RADDRI(RADDRI), .RCEBI(RCEBI), .UNIT_START(UNIT_START),
    .UNIT_BUSY(UNIT_BUSY), .AG_OUT(AG_OUT), .CTRL(CTRL),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!RCEBI) QI <= mem[RADDRI[3:0]];
  end

  always @(posedge CLK) begin
    for (int u = 0; u < N_UNIT; u++) begin
      if (RST) ucnt[u] <= 0;
      else if (UNIT_START[u]) ucnt[u] <= udur[u];
      else if (ucnt[u] > 0) ucnt[u] <= ucnt[u] - 1;
    end
  end

  assign UNIT_BUSY = {ucnt[2] > 0, tog1, ucnt[0] > 0};

  function automatic logic [39:0] ins(input logic [3:0] op, input logic [3:0] sel, input logic [31:0] imm);
    return {op, sel, imm};
  endfunction

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = ins(4'd8, 4'd0, 32'd0);
  endtask

  task automatic run_prog(input int budget, input logic [PCW-1:0] watch, output int cycles, output int hits);
    START = 1'b1; step(); START = 1'b0;
    cycles = 0; hits = 0;
    while (BUSY && cycles < budget) begin
      if (!RCEBI && RADDRI == watch) hits++;
      cycles++; tog1 = ~tog1; step();
    end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL run_timeout busy=%b exp=0 after %0d cycles", BUSY, cycles); end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; PURGE = 1'b0; tog1 = 1'b0;
    udur[0] = 5; udur[1] = 3; udur[2] = 9;
    clear_mem();
    repeat (3) step();
    RST = 1'b0; step();
    checks++; if (RCEBI !== 1'b1) begin errors++; $display("FAIL reset_rcebi got=%b exp=1", RCEBI); end
    checks++; if (RADDRI !== 14'd0) begin errors++; $display("FAIL reset_raddr got=%0h exp=0", RADDRI); end
    checks++; if ({BUSY, DONE, ERR} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {BUSY, DONE, ERR}); end
    checks++; if (UNIT_START !== 3'd0) begin errors++; $display("FAIL reset_ustart got=%b exp=000", UNIT_START); end
    checks++; if (CTRL !== 24'd0 || AG_OUT !== 48'd0) begin errors++; $display("FAIL reset_ctrl_ag ctrl=%0h ag=%0h exp=0", CTRL, AG_OUT); end
  endtask

  task automatic test_nop_halt();
    clear_mem();
    mem[0] = ins(4'd0, 4'd0, 32'd0);
    mem[1] = ins(4'd8, 4'd0, 32'd0);
    START = 1'b1; step(); START = 1'b0;
    checks++; if (RCEBI !== 1'b0 || RADDRI !== 14'd0 || BUSY !== 1'b1) begin errors++; $display("FAIL fetch0 rcebi=%b raddr=%0d busy=%b exp 0/0/1", RCEBI, RADDRI, BUSY); end
    step(); step();
    checks++; if (RCEBI !== 1'b0 || RADDRI !== 14'd1) begin errors++; $display("FAIL fetch1 rcebi=%b raddr=%0d exp 0/1", RCEBI, RADDRI); end
    step(); step();
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0 || RCEBI !== 1'b1) begin errors++; $display("FAIL halt done=%b busy=%b rcebi=%b exp 1/0/1", DONE, BUSY, RCEBI); end
  endtask

  task automatic test_loop();
    int cyc, hits;
    clear_mem();
    mem[0] = ins(4'd1, 4'd0, 32'd3);
    mem[1] = ins(4'd5, 4'd0, 32'd4);
    mem[2] = ins(4'd2, 4'd0, 32'd1);
    mem[3] = ins(4'd8, 4'd0, 32'd0);
    run_prog(100, 14'd1, cyc, hits);
    checks++; if (hits != 3) begin errors++; $display("FAIL loop_body_count got=%0d exp=3", hits); end
    checks++; if (cyc != 16) begin errors++; $display("FAIL loop_cycles got=%0d exp=16", cyc); end
    checks++; if (AG_OUT[15:0] !== 16'd12) begin errors++; $display("FAIL loop_ag0 got=%0h exp=c", AG_OUT[15:0]); end
    checks++; if (dut.cnt_q[0] !== 8'd0) begin errors++; $display("FAIL loop_cnt0 got=%0d exp=0", dut.cnt_q[0]); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL loop_done got=%b exp=1", DONE); end
  endtask

  task automatic test_ag_wrap();
    int cyc, hits;
    clear_mem();
    mem[0] = ins(4'd4, 4'd1, 32'h0002);
    mem[1] = ins(4'd5, 4'd1, 32'h0000_FFFF);
    mem[2] = ins(4'd7, 4'd0, 32'h00AB_CDEF);
    mem[3] = ins(4'd8, 4'd0, 32'd0);
    run_prog(100, 14'd3, cyc, hits);
    checks++; if (AG_OUT[31:16] !== 16'h0001) begin errors++; $display("FAIL ag1_neg_stride got=%0h exp=1", AG_OUT[31:16]); end
    checks++; if (CTRL !== 24'hABCDEF) begin errors++; $display("FAIL setctrl got=%0h exp=abcdef", CTRL); end
    checks++; if (AG_OUT[15:0] !== 16'd12) begin errors++; $display("FAIL ag0_retained got=%0h exp=c", AG_OUT[15:0]); end
    clear_mem();
    mem[0] = ins(4'd3, 4'd0, 32'd2);
    mem[1] = ins(4'd4, 4'd1, 32'd0);
    mem[2] = ins(4'd5, 4'd1, 32'h0000_FFFE);
    mem[3] = ins(4'd8, 4'd0, 32'd0);
    run_prog(100, 14'd1, cyc, hits);
    checks++; if (AG_OUT[31:16] !== 16'hFFFF) begin errors++; $display("FAIL ag1_wrap got=%0h exp=ffff", AG_OUT[31:16]); end
    checks++; if (hits != 0 || cyc != 6) begin errors++; $display("FAIL jmp_skip hits=%0d cyc=%0d exp 0/6", hits, cyc); end
  endtask

  task automatic test_run();
    int cyc = 0, npulse = 0, start_cyc = -1, fetch_cyc = -1;
    logic [N_UNIT-1:0] pval = '0;
    clear_mem();
    mem[0] = ins(4'd6, 4'd0, 32'b101);
    mem[1] = ins(4'd8, 4'd0, 32'd0);
    START = 1'b1; step(); START = 1'b0;
    while (BUSY && cyc < 60) begin
      if (UNIT_START != 3'd0) begin
        npulse++;
        if (start_cyc < 0) begin start_cyc = cyc; pval = UNIT_START; end
      end
      if (!RCEBI && RADDRI == 14'd1 && fetch_cyc < 0) fetch_cyc = cyc;
      tog1 = ~tog1; cyc++; step();
    end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL run_timeout busy=%b exp=0", BUSY); end
    checks++; if (npulse != 1 || pval !== 3'b101) begin errors++; $display("FAIL run_pulse count=%0d val=%b exp 1/101", npulse, pval); end
    checks++; if (fetch_cyc - start_cyc != 11) begin errors++; $display("FAIL run_wait_len got=%0d exp=11", fetch_cyc - start_cyc); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL run_done got=%b exp=1", DONE); end
  endtask

  task automatic test_err();
    int cyc, hits;
    clear_mem();
    mem[0] = ins(4'hC, 4'd0, 32'd0);
    run_prog(20, 14'd0, cyc, hits);
    checks++; if ({ERR, DONE} !== 2'b10 || cyc != 2) begin errors++; $display("FAIL bad_opcode err_done=%b cyc=%0d exp 10/2", {ERR, DONE}, cyc); end
    mem[0] = ins(4'd1, 4'd5, 32'd7);
    run_prog(20, 14'd0, cyc, hits);
    checks++; if ({ERR, DONE} !== 2'b10 || cyc != 2) begin errors++; $display("FAIL bad_sel err_done=%b cyc=%0d exp 10/2", {ERR, DONE}, cyc); end
    mem[0] = ins(4'd0, 4'd0, 32'd0);
    mem[1] = ins(4'd8, 4'd0, 32'd0);
    run_prog(20, 14'd0, cyc, hits);
    checks++; if ({ERR, DONE} !== 2'b01) begin errors++; $display("FAIL err_cleared err_done=%b exp 01", {ERR, DONE}); end
  endtask

  task automatic test_purge();
    int cyc = 0, n = 0, hits;
    clear_mem();
    mem[0] = ins(4'd7, 4'd0, 32'h0012_3456);
    mem[1] = ins(4'd4, 4'd2, 32'h0055);
    mem[2] = ins(4'd6, 4'd0, 32'b001);
    mem[3] = ins(4'd8, 4'd0, 32'd0);
    START = 1'b1; step(); START = 1'b0;
    while (UNIT_START == 3'd0 && cyc < 30) begin cyc++; step(); end
    checks++; if (UNIT_START !== 3'b001) begin errors++; $display("FAIL purge_setup ustart=%b exp=001", UNIT_START); end
    step();
    PURGE = 1'b1; START = 1'b1; step(); PURGE = 1'b0; START = 1'b0;
    checks++; if ({BUSY, DONE, ERR, RCEBI} !== 4'b0001) begin errors++; $display("FAIL purge_flags got=%b exp=0001", {BUSY, DONE, ERR, RCEBI}); end
    checks++; if (CTRL !== 24'd0 || AG_OUT !== 48'd0 || RADDRI !== 14'd0) begin errors++; $display("FAIL purge_clear ctrl=%0h ag=%0h raddr=%0d exp 0", CTRL, AG_OUT, RADDRI); end
    for (int i = 0; i < 6; i++) begin
      if (UNIT_START != 3'd0) n++;
      step();
    end
    checks++; if (n != 0) begin errors++; $display("FAIL purge_no_ustart got=%0d pulses exp=0", n); end
    clear_mem();
    mem[0] = ins(4'd0, 4'd0, 32'd0);
    mem[1] = ins(4'd8, 4'd0, 32'd0);
    run_prog(20, 14'd0, cyc, hits);
    checks++; if (hits != 1 || DONE !== 1'b1) begin errors++; $display("FAIL purge_restart hits=%0d done=%b exp 1/1", hits, DONE); end
  endtask

  initial begin
    test_reset();
    test_nop_halt();
    test_loop();
    test_ag_wrap();
    test_run();
    test_err();
    test_purge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
